// File: rtl/fifo_stat_regs.sv
// Status and interrupt register block for up to eight monitored FIFOs.
// Each channel has a live count and flags, a high-water mark and a threshold.
// There is a shared 24-bit sticky interrupt status (threshold, overflow and
// underflow per channel), an interrupt enable, and a saturating overflow
// event counter.
// Bus protocol: a request is qualified by req_valid. With req_write=1 it
// commits at the rising clk edge and has no handshake back. With req_write=0,
// rdata is a combinational function of req_addr and the registered state, so
// it is valid in the same cycle.
module fifo_stat_regs #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 9,
  parameter int EVT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [3:0]                req_wstrb,
  output logic [31:0]               rdata,
  input  logic [NUM_CH*CNT_W-1:0]   ch_count,
  input  logic [NUM_CH-1:0]         ch_empty,
  input  logic [NUM_CH-1:0]         ch_full,
  input  logic [NUM_CH-1:0]         ch_push,
  input  logic [NUM_CH-1:0]         ch_pop,
  output logic                      irq
);

  localparam logic [32:0] EVT_MAX = (33'd1 << EVT_W) - 33'd1;

  logic [CNT_W-1:0] hiwater [NUM_CH];
  logic [CNT_W-1:0] thresh  [NUM_CH];
  logic [NUM_CH-1:0] cmp_q;
  logic [23:0]      irq_en;
  logic [23:0]      irq_stat;
  logic [EVT_W-1:0] ovf_total;

  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0] cmp_now, thr_evt, ovf_evt, udf_evt;
  logic [NUM_CH-1:0] thr_wr, hw_wr;
  logic [23:0]      valid_mask, set_vec, w1c_vec, irq_stat_next;
  logic [3:0]       ovf_cnt;
  logic [32:0]      ovf_sum;
  logic [EVT_W-1:0] ovf_next;

  logic [7:0] a;
  logic       is_ch, wr_en, en_wr, stat_wr, ovf_wr;
  logic [2:0] ch_idx;
  logic [3:0] off;

  // Address bits above [7:0], the top write-data byte and the top strobe
  // are not part of the map.
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:8], req_wdata[31:24], req_wstrb[3]};

  assign a       = req_addr[7:0];
  assign is_ch   = ~a[7];
  assign ch_idx  = a[6:4];
  assign off     = a[3:0];
  assign wr_en   = req_valid & req_write;
  assign en_wr   = wr_en & (a == 8'h80);
  assign stat_wr = wr_en & (a == 8'h84);
  assign ovf_wr  = wr_en & (a == 8'h88);

  // Per-channel decode, live count slicing and event detection.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt[c]     = ch_count[c*CNT_W +: CNT_W];
      cmp_now[c] = (cnt[c] >= thresh[c]);
      thr_evt[c] = cmp_now[c] & ~cmp_q[c];
      ovf_evt[c] = ch_push[c] & ch_full[c];
      udf_evt[c] = ch_pop[c] & ch_empty[c];
      thr_wr[c]  = wr_en & is_ch & (ch_idx == 3'(c)) & (off == 4'hC);
      hw_wr[c]   = wr_en & is_ch & (ch_idx == 3'(c)) & (off == 4'h8);
    end
  end

  // Sticky status next-state: set vector, W1C vector, and the mask that
  // keeps bits of absent channels at zero. A set beats a clear.
  always_comb begin
    valid_mask = '0;
    set_vec    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      valid_mask[c]      = 1'b1;
      valid_mask[8 + c]  = 1'b1;
      valid_mask[16 + c] = 1'b1;
      set_vec[c]         = thr_evt[c];
      set_vec[8 + c]     = ovf_evt[c];
      set_vec[16 + c]    = udf_evt[c];
    end
    w1c_vec = '0;
    if (stat_wr) begin
      for (int b = 0; b < 24; b++)
        w1c_vec[b] = req_wdata[b] & req_wstrb[b/8];
    end
    irq_stat_next = ((irq_stat & ~w1c_vec) | set_vec) & valid_mask;
  end

  // Overflow counter next-state: a write restarts from zero, then this
  // cycle's event popcount is added with saturation.
  always_comb begin
    ovf_cnt = '0;
    for (int c = 0; c < NUM_CH; c++)
      ovf_cnt = ovf_cnt + 4'(ovf_evt[c]);
    ovf_sum = (ovf_wr ? 33'd0 : 33'(ovf_total)) + 33'(ovf_cnt);
    if (ovf_sum > EVT_MAX)
      ovf_next = EVT_MAX[EVT_W-1:0];
    else
      ovf_next = ovf_sum[EVT_W-1:0];
  end

  // Per-channel registers: threshold (byte-strobed), high-water, and the
  // previous-cycle compare result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        hiwater[c] <= '0;
        thresh[c]  <= '0;
      end
      cmp_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hw_wr[c] || (cnt[c] > hiwater[c]))
          hiwater[c] <= cnt[c];
        if (thr_wr[c]) begin
          for (int b = 0; b < CNT_W; b++)
            if (req_wstrb[b/8]) thresh[c][b] <= req_wdata[b];
        end
      end
      cmp_q <= cmp_now;
    end
  end

  // Global registers: interrupt enable, sticky status, overflow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en    <= '0;
      irq_stat  <= '0;
      ovf_total <= '0;
    end else begin
      if (en_wr) begin
        for (int b = 0; b < 24; b++)
          if (req_wstrb[b/8]) irq_en[b] <= req_wdata[b];
      end
      irq_stat  <= irq_stat_next;
      ovf_total <= ovf_next;
    end
  end

  // Combinational read mux; unmapped offsets and absent channels read 0.
  always_comb begin
    rdata = '0;
    if (is_ch) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 3'(c)) begin
          case (off)
            4'h0: rdata = 32'(cnt[c]);
            4'h4: rdata = {27'd0, irq_stat[16 + c], irq_stat[8 + c],
                           irq_stat[c], ch_full[c], ch_empty[c]};
            4'h8: rdata = 32'(hiwater[c]);
            4'hC: rdata = 32'(thresh[c]);
            default: rdata = '0;
          endcase
        end
      end
    end else begin
      case (a)
        8'h80: rdata = {8'd0, irq_en};
        8'h84: rdata = {8'd0, irq_stat};
        8'h88: rdata = 32'(ovf_total);
        default: rdata = '0;
      endcase
    end
  end

  // Level interrupt from enabled sticky status.
  assign irq = |(irq_stat & irq_en);

endmodule

// File: tb/tb_fifo_stat_regs.sv
// Directed testbench for fifo_stat_regs (NUM_CH=2, CNT_W=9). A second
// instance with EVT_W=2 shares every input and is used for saturation.
module tb_fifo_stat_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] rdata, rdata_s;
  logic [17:0] ch_count;
  logic [1:0]  ch_empty, ch_full, ch_push, ch_pop;
  logic        irq, irq_s_unused;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  fifo_stat_regs #(.NUM_CH(2), .CNT_W(9), .EVT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rdata(rdata), .ch_count(ch_count), .ch_empty(ch_empty),
    .ch_full(ch_full), .ch_push(ch_push), .ch_pop(ch_pop), .irq(irq)
  );

  fifo_stat_regs #(.NUM_CH(2), .CNT_W(9), .EVT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rdata(rdata_s), .ch_count(ch_count), .ch_empty(ch_empty),
    .ch_full(ch_full), .ch_push(ch_push), .ch_pop(ch_pop), .irq(irq_s_unused)
  );

  // Scoreboard: pop the oldest expectation and compare.
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h, no expected value queued", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks: all start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data,
                    input logic [3:0] strb);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = {24'd0, addr};
    req_wdata = data;
    req_wstrb = strb;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp,
                    input string tag);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = {24'd0, addr};
    exp_q.push_back(exp);
    #2;
    check(tag, rdata);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic rd_sat(input logic [7:0] addr, input logic [31:0] exp,
                        input string tag);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = {24'd0, addr};
    exp_q.push_back(exp);
    #2;
    check(tag, rdata_s);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    exp_q.push_back({31'd0, exp});
    #2;
    check(tag, {31'd0, irq});
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0;
    ch_count = '0; ch_empty = 2'b11; ch_full = 2'b00;
    ch_push = 2'b00; ch_pop = 2'b00;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state (IRQ_STAT first: THRESH=0 makes count>=THRESH rise
    // on the first edge after reset).
    rd(8'h84, 32'h0, "rst_irq_stat");
    chk_irq(1'b0, "rst_irq");
    rd(8'h80, 32'h0, "rst_irq_en");
    rd(8'h88, 32'h0, "rst_ovf");
    rd(8'h08, 32'h0, "rst_hiwater0");
    rd(8'h0C, 32'h0, "rst_thresh0");
    rd(8'h18, 32'h0, "rst_hiwater1");

    // Threshold crossing 3 -> 4 -> 5 with THRESH0=4
    ch_empty = 2'b00;
    ch_count[8:0] = 9'd3;
    wr(8'h0C, 32'd4, 4'hF);
    wr(8'h84, 32'h00FF_FFFF, 4'h7);
    wr(8'h80, 32'h1, 4'h1);
    rd(8'h84, 32'h0, "thr_pre");
    ch_count[8:0] = 9'd4;
    chk_irq(1'b0, "thr_irq_same_cycle");
    chk_irq(1'b1, "thr_irq_next_cycle");
    ch_count[8:0] = 9'd5;
    rd(8'h84, 32'h1, "thr_stat_once");
    ch_count[8:0] = 9'd6;
    wr(8'h84, 32'h1, 4'h1);
    rd(8'h84, 32'h0, "thr_w1c_no_refire");
    chk_irq(1'b0, "thr_irq_cleared");

    // THRESH write that makes the compare true fires one cycle later
    wr(8'h0C, 32'd7, 4'hF);
    wr(8'h0C, 32'd6, 4'hF);
    rd(8'h84, 32'h0, "thr_wr_cycle0");
    rd(8'h84, 32'h1, "thr_wr_cycle1");
    wr(8'h84, 32'h1, 4'h1);

    // Overflow on channel 1: 3 pulses, then 2 more
    ch_full = 2'b10;
    ch_push = 2'b10;
    repeat (3) tick();
    ch_push = 2'b00;
    rd(8'h88, 32'd3, "ovf_total_3");
    rd_sat(8'h88, 32'd3, "ovf_sat_3");
    rd(8'h84, 32'h200, "ovf_stat_bit9");
    rd(8'h14, 32'hA, "ovf_status_ch1");
    ch_push = 2'b10;
    repeat (2) tick();
    ch_push = 2'b00;
    rd(8'h88, 32'd5, "ovf_total_5");
    rd_sat(8'h88, 32'd3, "ovf_saturated");

    // OVF_TOTAL write coinciding with overflow on both channels
    ch_full = 2'b11;
    ch_push = 2'b11;
    wr(8'h88, 32'h0, 4'hF);
    ch_push = 2'b00;
    rd(8'h88, 32'd2, "ovf_wr_collide");
    rd_sat(8'h88, 32'd2, "ovf_wr_collide_sat");
    wr(8'h84, 32'h00FF_FFFF, 4'h7);
    rd(8'h84, 32'h0, "stat_clear_all");

    // Underflow on channel 0 vs W1C of bit16
    ch_empty = 2'b01;
    ch_pop = 2'b01;
    tick();
    ch_pop = 2'b00;
    rd(8'h84, 32'h1_0000, "udf_set");
    ch_pop = 2'b01;
    wr(8'h84, 32'h1_0000, 4'h4);
    ch_pop = 2'b00;
    rd(8'h84, 32'h1_0000, "udf_beats_w1c");
    wr(8'h84, 32'h1_0000, 4'h3);
    rd(8'h84, 32'h1_0000, "w1c_lane_unstrobed");
    wr(8'h84, 32'h1_0000, 4'h4);
    rd(8'h84, 32'h0, "w1c_lane_strobed");

    // High-water: 0, 7, 2 then clear-by-write at 2
    ch_count[8:0] = 9'd0;
    wr(8'h08, 32'h0, 4'hF);
    rd(8'h08, 32'd0, "hw_cleared");
    ch_count[8:0] = 9'd7;
    tick();
    ch_count[8:0] = 9'd2;
    tick();
    rd(8'h08, 32'd7, "hw_max");
    wr(8'h08, 32'h0, 4'h0);
    rd(8'h08, 32'd2, "hw_wr_loads_count");

    // Decode and byte strobes
    rd(8'h20, 32'h0, "dec_ch2_count");
    rd(8'h2C, 32'h0, "dec_ch2_thresh");
    rd(8'h01, 32'h0, "dec_unaligned");
    rd(8'h8C, 32'h0, "dec_global_hole");
    wr(8'h0C, 32'hFFFF_FFFF, 4'h2);
    rd(8'h0C, 32'h106, "thresh_lane1_only");
    wr(8'h80, 32'hFFFF_FFFF, 4'h5);
    rd(8'h80, 32'h00FF_00FF, "irq_en_lanes");
    wr(8'h00, 32'h55, 4'hF);
    rd(8'h00, 32'd2, "count_ro");
    wr(8'h84, 32'h00FF_FFFF, 4'h7);
    chk_irq(1'b0, "irq_after_clear");

    // Mid-run reset with sticky bits set and events/writes during reset
    ch_count = '0;
    ch_empty = 2'b11;
    ch_pop = 2'b11;
    tick();
    ch_pop = 2'b00;
    ch_push = 2'b11;
    tick();
    ch_push = 2'b00;
    rd(8'h84, 32'h3_0300, "pre_rst_stat");
    chk_irq(1'b1, "pre_rst_irq");
    rst = 1'b1;
    ch_pop = 2'b11;
    ch_push = 2'b11;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0C;
    req_wdata = 32'd5; req_wstrb = 4'hF;
    tick();
    rst = 1'b0;
    ch_pop = 2'b00; ch_push = 2'b00; ch_full = 2'b00;
    req_valid = 1'b0; req_write = 1'b0; req_wstrb = 4'h0;
    rd(8'h84, 32'h0, "mid_rst_stat");
    chk_irq(1'b0, "mid_rst_irq");
    rd(8'h80, 32'h0, "mid_rst_irq_en");
    rd(8'h88, 32'h0, "mid_rst_ovf");
    rd_sat(8'h88, 32'h0, "mid_rst_ovf_sat");
    rd(8'h0C, 32'h0, "mid_rst_thresh");
    rd(8'h08, 32'h0, "mid_rst_hiwater");
    // Empty flag live, plus the threshold bit raised because the compare
    // register restarted at 0 while THRESH=0.
    rd(8'h04, 32'h5, "post_rst_status");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
